pio_seq_s: RTL and testbench
============================

// Module: pio_seq_s
// PURPOSE
//  Pattern sequencer and bus sharer for one pio_s port. It owns the pio_s register bus, passes CPU accesses
//  through with absolute priority, and in idle bus cycles writes a table of (data, delay) entries to the port's
//  PORT_OUT register. This lets firmware offload bit-bang waveforms and get a DONE interrupt at the end.
// PARAMETERS
//  ADDRESS            0     base of this block's 8-byte register window (CPU side)
//  PIO_ADDRESS        0     base of the target pio_s; writes go to PIO_ADDRESS + `PORT_OUT (io_s_h.v)
//  DEPTH              16    table entries, power of 2, 2..256
//  BUS_ADDR_DATA_LEN  16    address width
// PORTS
//  clk         in   1    clock
//  rst_n       in   1    asynchronous active-low reset
//  cpu_addr    in   BUS_ADDR_DATA_LEN  CPU address
//  cpu_wr      in   1    CPU write strobe
//  cpu_rd      in   1    CPU read strobe
//  cpu_bus_in  in   8    CPU write data
//  cpu_bus_out out  8    read data from this block's window; 8'h00 when not selected
//  pio_addr    out  BUS_ADDR_DATA_LEN  to pio_s addr
//  pio_wr      out  1    to pio_s wr
//  pio_rd      out  1    to pio_s rd
//  pio_bus_in  out  8    to pio_s bus_in
//  int         out  1    DONE interrupt = STATUS.DONE & CTRL.IRQEN
//  int_rst     in   1    one-cycle pulse, clears STATUS.DONE
// BEHAVIOUR
//  Registers (offset from ADDRESS):
//   0 CTRL: b0 EN, b1 LOOP, b2 IRQEN, b3 TRIGMODE
//   1 STATUS (RO except DONE): b0 BUSY, b1 DONE (write 1 clears)
//   2 LEN: entries to play, 0..DEPTH
//   3 PRESC: delay tick = PRESC+1 clocks
//   4 IDX: table write pointer
//   5 TDATA: table data write
//   6 TDLY: table delay write; IDX post-increments, wrapping at DEPTH
//  Table RAM is write-only from the CPU; reads of offsets 5 and 6 return 8'h00.
//  Table and LEN/PRESC writes while BUSY are ignored.
//  Reset: all registers 0, FSM IDLE, cpu_bus_out=0, pio_wr=pio_rd=0, pio_addr=0, pio_bus_in=0, int=0.
//  Bus mux (combinational): if cpu_wr|cpu_rd, the pio_* outputs mirror the cpu_* inputs; otherwise pio_wr=seq_req,
//   pio_addr=PIO_ADDRESS+`PORT_OUT, pio_bus_in=current entry data.
//  The CPU never stalls.
//  FSM:
//   IDLE->START when a CPU write sets CTRL.EN=1 (BUSY=1, ptr=0).
//   START->ISSUE. In START, if TRIGMODE=1 (feature only), wait for a trig rising edge. If LEN=0, go to FIN.
//   ISSUE: seq_req=1. The write completes in the first clock with no CPU strobe; that clock loads the delay counter
//    with (TDLY[ptr]+1)*(PRESC+1)-1 (16-bit, saturating), then ->WAIT.
//   WAIT counts down to 0. On 0, ptr++:
//    - ptr<LEN -> ISSUE;
//    - else LOOP=1 -> ptr=0, ISSUE;
//    - else -> FIN.
//   FIN: DONE=1, EN=0, BUSY=0 ->IDLE.
//  Timing: with a free bus, consecutive PORT_OUT writes are exactly (TDLY+1)*(PRESC+1) clocks apart.
//   The first write is 2 clocks after the CTRL write.
//  A CPU write of CTRL.EN=0 in any non-IDLE state aborts to IDLE next clock: the pending write is dropped, DONE is
//   unchanged, BUSY=0.
//  If int_rst and a FIN occur in the same cycle, the DONE set wins.
//  A W1C to DONE in the same cycle as FIN: set wins.
//  rst_n assertion mid-sequence aborts immediately and no further pio_wr is issued.
// CONFIGURATION
//  PIO_SEQ_TRIG_EN defined:
//   - adds input port trig (1 bit, async), double-flop synchronised, with rising-edge detect;
//   - CTRL.TRIGMODE is writable; START waits for a trig edge (start latency = edge + 3 clocks);
//   - with LOOP=1 each pass re-arms and waits for a new edge.
//  Undefined: no trig port, TRIGMODE reads 0 and writes are ignored.
// TESTING
//  1. LEN=2, PRESC=0, table {A5/d1, 5A/d0}, EN=1 -> pio_wr data A5 at t+2, 5A at t+4, DONE=1, int if IRQEN.
//  2. Same as 1 with cpu_rd held on the cycle of the first write -> CPU passes through and the A5 write slips 1 clock.
//  3. LOOP=1, LEN=1, data 0F/d2, PRESC=1 -> 0F written every 6 clocks; EN=0 -> no further writes, DONE stays 0.
//  4. LEN=0, EN=1 -> no pio_wr; DONE=1 after 2 clocks; int_rst clears DONE.
//  5. Write IDX=DEPTH-1, then TDATA/TDLY twice -> entries DEPTH-1 and 0 are filled and IDX reads 1.
//  6. PIO_SEQ_TRIG_EN, TRIGMODE=1, EN=1 -> no write until trig rises; first write 3 clocks after the edge.

Source files
------------

// File: rtl/pio_seq_s_if.sv
// CPU-side register bus plus the shared pio_s bus driven by pio_seq_s.
interface pio_seq_s_if #(
  parameter int AW = 16
) ();
  logic [AW-1:0] cpu_addr;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [7:0]    cpu_bus_in;
  logic [7:0]    cpu_bus_out;
  logic [AW-1:0] pio_addr;
  logic          pio_wr;
  logic          pio_rd;
  logic [7:0]    pio_bus_in;
  logic          intr;
  logic          int_rst;

  modport master (
    output cpu_addr, cpu_wr, cpu_rd, cpu_bus_in, int_rst,
    input  cpu_bus_out, pio_addr, pio_wr, pio_rd, pio_bus_in, intr
  );
  modport slave (
    input  cpu_addr, cpu_wr, cpu_rd, cpu_bus_in, int_rst,
    output cpu_bus_out, pio_addr, pio_wr, pio_rd, pio_bus_in, intr
  );
endinterface

// File: rtl/pio_seq_s.sv
// Plays a (data, delay) table into pio_s PORT_OUT in idle bus cycles; first write 2 clocks after EN, CPU never stalls
// (CPU strobes always win the pio bus). Optional trigger start gated by PIO_SEQ_TRIG_EN.
`ifndef PORT_OUT
`define PORT_OUT 2
`endif
module pio_seq_s #(
  parameter int unsigned ADDRESS           = 0,
  parameter int unsigned PIO_ADDRESS       = 0,
  parameter int          DEPTH             = 16,
  parameter int          BUS_ADDR_DATA_LEN = 16
) (
  input logic        clk,
  input logic        rst_n,
`ifdef PIO_SEQ_TRIG_EN
  input logic        trig,
`endif
  pio_seq_s_if.slave io
);
  localparam int AW = BUS_ADDR_DATA_LEN;
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] BASE    = AW'(ADDRESS);
  localparam logic [AW-1:0] WR_ADDR = AW'(PIO_ADDRESS + `PORT_OUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]    state;
  logic          en, loop, irqen, trigmode, done;
  logic [7:0]    len, presc;
  logic [IW-1:0] idx, ptr;
  logic [15:0]   cnt;
  logic [7:0]    tdata_mem [DEPTH];
  logic [7:0]    tdly_mem  [DEPTH];

  logic       sel, cpu_act, busy, seq_req, wait_trig;
  logic [2:0] ofs;
  logic [7:0] din;
  logic       wr_ctrl, wr_stat, wr_len, wr_presc, wr_idx, wr_tdata, wr_tdly, abort;

  assign sel      = io.cpu_addr[AW-1:3] == BASE[AW-1:3];
  assign ofs      = io.cpu_addr[2:0];
  assign din      = io.cpu_bus_in;
  assign cpu_act  = io.cpu_wr | io.cpu_rd;
  assign busy     = state != S_IDLE;
  assign seq_req  = state == S_ISSUE;
  assign wr_ctrl  = io.cpu_wr & sel & (ofs == 3'd0);
  assign wr_stat  = io.cpu_wr & sel & (ofs == 3'd1);
  assign wr_len   = io.cpu_wr & sel & (ofs == 3'd2) & ~busy;
  assign wr_presc = io.cpu_wr & sel & (ofs == 3'd3) & ~busy;
  assign wr_idx   = io.cpu_wr & sel & (ofs == 3'd4) & ~busy;
  assign wr_tdata = io.cpu_wr & sel & (ofs == 3'd5) & ~busy;
  assign wr_tdly  = io.cpu_wr & sel & (ofs == 3'd6) & ~busy;
  assign abort    = wr_ctrl & ~din[0] & busy;

`ifdef PIO_SEQ_TRIG_EN
  logic trig_s1, trig_s2, trig_s3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
    end
  end
  assign wait_trig = trigmode & ~(trig_s2 & ~trig_s3);
`else
  assign wait_trig = 1'b0;
`endif

  // Delay in clocks minus one; product tops out at 65535 for 8-bit fields, saturation is a guard.
  logic [17:0] prod, prod_m1;
  logic [15:0] dly;
  assign prod    = 18'({1'b0, tdly_mem[ptr]} + 9'd1) * 18'({1'b0, presc} + 9'd1);
  assign prod_m1 = prod - 18'd1;
  assign dly     = (|prod_m1[17:16]) ? 16'hFFFF : prod_m1[15:0];

  logic [8:0]    nxt9;
  logic [2:0]    adv_state;
  logic [IW-1:0] adv_ptr;
  always_comb begin
    nxt9      = 9'(ptr) + 9'd1;
    adv_state = S_FIN;
    adv_ptr   = ptr;
    if (nxt9 < {1'b0, len} && nxt9 < 9'(DEPTH)) begin
      adv_state = S_ISSUE;
      adv_ptr   = nxt9[IW-1:0];
    end else if (loop) begin
      adv_state = trigmode ? S_START : S_ISSUE;
      adv_ptr   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      en       <= 1'b0;
      loop     <= 1'b0;
      irqen    <= 1'b0;
      trigmode <= 1'b0;
      done     <= 1'b0;
      len      <= 8'd0;
      presc    <= 8'd0;
      idx      <= '0;
      ptr      <= '0;
      cnt      <= 16'd0;
    end else begin
      if (wr_ctrl) begin
        en    <= din[0];
        loop  <= din[1];
        irqen <= din[2];
`ifdef PIO_SEQ_TRIG_EN
        trigmode <= din[3];
`else
        trigmode <= 1'b0;
`endif
      end
      if (wr_len)   len   <= din;
      if (wr_presc) presc <= din;
      if (wr_idx)   idx   <= din[IW-1:0];
      else if (wr_tdly) idx <= idx + 1'b1;

      // FIN sets DONE ahead of int_rst and the W1C path.
      if (state == S_FIN && !abort) done <= 1'b1;
      else if (io.int_rst || (wr_stat && din[1])) done <= 1'b0;

      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (wr_ctrl && din[0]) begin
            state <= S_START;
            ptr   <= '0;
          end
          S_START: if (!wait_trig) state <= (len == 8'd0) ? S_FIN : S_ISSUE;
          S_ISSUE: if (!cpu_act) begin
            if (dly == 16'd0) begin
              state <= adv_state;
              ptr   <= adv_ptr;
            end else begin
              cnt   <= dly;
              state <= S_WAIT;
            end
          end
          S_WAIT: if (cnt <= 16'd1) begin
            state <= adv_state;
            ptr   <= adv_ptr;
          end else begin
            cnt <= cnt - 16'd1;
          end
          S_FIN: begin
            state <= S_IDLE;
            en    <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_tdata) tdata_mem[idx] <= din;
    if (wr_tdly)  tdly_mem[idx]  <= din;
  end

  always_comb begin
    io.pio_wr     = seq_req;
    io.pio_rd     = 1'b0;
    io.pio_addr   = seq_req ? WR_ADDR : '0;
    io.pio_bus_in = seq_req ? tdata_mem[ptr] : 8'h00;
    if (cpu_act) begin
      io.pio_wr     = io.cpu_wr;
      io.pio_rd     = io.cpu_rd;
      io.pio_addr   = io.cpu_addr;
      io.pio_bus_in = io.cpu_bus_in;
    end
  end

  always_comb begin
    io.cpu_bus_out = 8'h00;
    if (sel && io.cpu_rd) begin
      case (ofs)
        3'd0:    io.cpu_bus_out = {4'b0, trigmode, irqen, loop, en};
        3'd1:    io.cpu_bus_out = {6'b0, done, busy};
        3'd2:    io.cpu_bus_out = len;
        3'd3:    io.cpu_bus_out = presc;
        3'd4:    io.cpu_bus_out = 8'(idx);
        default: io.cpu_bus_out = 8'h00;
      endcase
    end
  end

  assign io.intr = done & irqen;
endmodule

// File: tb/tb_pio_seq_s.sv
// Directed bench for pio_seq_s: table playback timing, bus sharing, loop/abort, DONE/IRQ and reset.
`ifndef PORT_OUT
`define PORT_OUT 2
`endif
module tb_pio_seq_s;
  localparam logic [15:0] BASE  = 16'h0040;
  localparam logic [15:0] PIOB  = 16'h0100;
  localparam logic [15:0] A_CTRL = BASE + 16'd0;
  localparam logic [15:0] A_STAT = BASE + 16'd1;
  localparam logic [15:0] A_LEN  = BASE + 16'd2;
  localparam logic [15:0] A_PRSC = BASE + 16'd3;
  localparam logic [15:0] A_IDX  = BASE + 16'd4;
  localparam logic [15:0] A_TDAT = BASE + 16'd5;
  localparam logic [15:0] A_TDLY = BASE + 16'd6;
  localparam logic [15:0] PORT_ADDR = PIOB + 16'(`PORT_OUT);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pio_seq_s_if #(.AW(16)) io ();
`ifdef PIO_SEQ_TRIG_EN
  logic trig;
`endif

  pio_seq_s #(
    .ADDRESS(32'h40), .PIO_ADDRESS(32'h100), .DEPTH(16), .BUS_ADDR_DATA_LEN(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PIO_SEQ_TRIG_EN
    .trig(trig),
`endif
    .io(io)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t wq[$];
  always @(negedge clk)
    if (io.pio_wr && !io.cpu_wr && !io.cpu_rd) wq.push_back('{cyc + 1, io.pio_addr, io.pio_bus_in});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int t);
    @(posedge clk); #1;
    io.cpu_addr = a; io.cpu_bus_in = d; io.cpu_wr = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    io.cpu_wr = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    int t;
    cpu_write(a, d, t);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] v;
    @(posedge clk); #1;
    io.cpu_addr = a; io.cpu_rd = 1'b1;
    @(negedge clk);
    v = io.cpu_bus_out;
    @(posedge clk); #1;
    io.cpu_rd = 1'b0;
    chk(tag, 32'(v), 32'(exp));
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t, ta;
    rst_n = 1'b0;
    io.cpu_addr = '0; io.cpu_wr = 1'b0; io.cpu_rd = 1'b0; io.cpu_bus_in = '0; io.int_rst = 1'b0;
`ifdef PIO_SEQ_TRIG_EN
    trig = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_intr", 32'(io.intr), 0);
    chk("rst_pio_wr", 32'(io.pio_wr), 0);
    chk("rst_pio_addr", 32'(io.pio_addr), 0);
    chk("rst_pio_bus_in", 32'(io.pio_bus_in), 0);
    chk("rst_cpu_bus_out", 32'(io.cpu_bus_out), 0);
    rst_n = 1'b1;
    rd_chk("rst_ctrl", A_CTRL, 8'h00);
    rd_chk("rst_status", A_STAT, 8'h00);
    rd_chk("rst_len", A_LEN, 8'h00);

    // Table {A5/d1, 5A/d0}, LEN=2, PRESC=0
    wr(A_IDX, 8'd0); wr(A_TDAT, 8'hA5); wr(A_TDLY, 8'd1); wr(A_TDAT, 8'h5A); wr(A_TDLY, 8'd0);
    wr(A_LEN, 8'd2); wr(A_PRSC, 8'd0);
    rd_chk("tdata_reads_zero", A_TDAT, 8'h00);
    rd_chk("idx_after_load", A_IDX, 8'h02);

    wq.delete();
    cpu_write(A_CTRL, 8'h05, t);
    repeat (8) @(posedge clk);
    #1;
    chk("t1_count", 32'(wq.size()), 2);
    chk("t1_w0_time", 32'(wq[0].at), 32'(t + 2));
    chk("t1_w0_addr", 32'(wq[0].a), 32'(PORT_ADDR));
    chk("t1_w0_data", 32'(wq[0].d), 32'h A5);
    chk("t1_w1_time", 32'(wq[1].at), 32'(t + 4));
    chk("t1_w1_data", 32'(wq[1].d), 32'h5A);
    chk("t1_intr", 32'(io.intr), 1);
    rd_chk("t1_status", A_STAT, 8'h02);
    rd_chk("t1_ctrl_en_cleared", A_CTRL, 8'h04);
    wr(A_STAT, 8'h02);
    chk("w1c_intr", 32'(io.intr), 0);

    // CPU read on the first write cycle pushes the sequence back one clock
    wq.delete();
    cpu_write(A_CTRL, 8'h05, t);
    @(posedge clk); #1;
    io.cpu_addr = A_IDX; io.cpu_rd = 1'b1;
    @(negedge clk);
    chk("t2_pio_rd_pass", 32'(io.pio_rd), 1);
    chk("t2_pio_wr_held", 32'(io.pio_wr), 0);
    chk("t2_pio_addr_pass", 32'(io.pio_addr), 32'(A_IDX));
    @(posedge clk); #1;
    io.cpu_rd = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t2_count", 32'(wq.size()), 2);
    chk("t2_w0_time", 32'(wq[0].at), 32'(t + 3));
    chk("t2_w1_time", 32'(wq[1].at), 32'(t + 5));
    wr(A_STAT, 8'h02);

    // Loop LEN=1, 0F/d2, PRESC=1 -> every 6 clocks; abort after three writes
    wr(A_IDX, 8'd0); wr(A_TDAT, 8'h0F); wr(A_TDLY, 8'd2); wr(A_LEN, 8'd1); wr(A_PRSC, 8'd1);
    wq.delete();
    cpu_write(A_CTRL, 8'h03, t);
    repeat (3) @(posedge clk);
    wr(A_LEN, 8'd5);
    wait_edge(t + 14);
    cpu_write(A_CTRL, 8'h02, ta);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_count", 32'(wq.size()), 3);
    chk("t3_w0_data", 32'(wq[0].d), 32'h0F);
    chk("t3_w1_time", 32'(wq[1].at), 32'(t + 8));
    chk("t3_w2_time", 32'(wq[2].at), 32'(t + 14));
    rd_chk("t3_status", A_STAT, 8'h00);
    rd_chk("t3_len_busy_ignored", A_LEN, 8'h01);
    rd_chk("t3_ctrl", A_CTRL, 8'h02);

    // LEN=0: no writes, DONE two clocks after EN
    wr(A_LEN, 8'd0);
    wq.delete();
    cpu_write(A_CTRL, 8'h05, t);
    wait_edge(t + 1);
    @(negedge clk);
    chk("t4_intr_early", 32'(io.intr), 0);
    wait_edge(t + 2);
    @(negedge clk);
    chk("t4_intr_set", 32'(io.intr), 1);
    chk("t4_no_writes", 32'(wq.size()), 0);
    @(posedge clk); #1; io.int_rst = 1'b1;
    @(posedge clk); #1; io.int_rst = 1'b0;
    chk("t4_int_rst", 32'(io.intr), 0);

    // FIN coinciding with int_rst and a DONE W1C: set wins
    cpu_write(A_CTRL, 8'h05, t);
    wait_edge(t + 1);
    io.int_rst = 1'b1;
    io.cpu_addr = A_STAT; io.cpu_bus_in = 8'h02; io.cpu_wr = 1'b1;
    @(posedge clk); #1;
    io.int_rst = 1'b0; io.cpu_wr = 1'b0;
    rd_chk("t4b_done_wins", A_STAT, 8'h02);
    wr(A_STAT, 8'h02);

    // IDX wraps at DEPTH
    wr(A_IDX, 8'd15); wr(A_TDAT, 8'h11); wr(A_TDLY, 8'd3); wr(A_TDAT, 8'h22); wr(A_TDLY, 8'd0);
    rd_chk("t5_idx_wrap", A_IDX, 8'h01);
    wr(A_LEN, 8'd1); wr(A_PRSC, 8'd0);
    wq.delete();
    cpu_write(A_CTRL, 8'h01, t);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_count", 32'(wq.size()), 1);
    chk("t5_entry0", 32'(wq[0].d), 32'h22);
    chk("t5_time", 32'(wq[0].at), 32'(t + 2));
    chk("t5_no_irq", 32'(io.intr), 0);
    wr(A_STAT, 8'h02);

    wr(A_CTRL, 8'h08);
`ifdef PIO_SEQ_TRIG_EN
    rd_chk("trigmode_rw", A_CTRL, 8'h08);
    wq.delete();
    cpu_write(A_CTRL, 8'h09, t);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_waits_trig", 32'(wq.size()), 0);
    trig = 1'b1;
    t = cyc;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_count", 32'(wq.size()), 1);
    chk("t6_time", 32'(wq[0].at), 32'(t + 4));
    trig = 1'b0;
    wr(A_STAT, 8'h02);
`else
    rd_chk("trigmode_ignored", A_CTRL, 8'h00);
`endif

    // Reset mid-sequence: entry 0 (22/d0) looping writes every clock
    cpu_write(A_CTRL, 8'h03, t);
    repeat (5) @(posedge clk);
    #1;
    chk("t7_running", 32'(wq.size() > 0), 1);
    rst_n = 1'b0;
    wq.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("t7_no_writes", 32'(wq.size()), 0);
    chk("t7_pio_wr", 32'(io.pio_wr), 0);
    rst_n = 1'b1;
    rd_chk("t7_ctrl", A_CTRL, 8'h00);
    rd_chk("t7_len", A_LEN, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
